// File: rtl/float_field_arbiter.sv
// rtl/float_field_arbiter.sv - round-robin arbiter feeding one shared float consumer
//
// Purpose: N requesters offer {sign, exponent, significand} bundles over
// ready/valid. One winner per cycle is registered into a one-entry output
// stage together with its source index and IEEE-754 class flags.
//
// Ports:
//   clock, reset                  rising-edge clock, synchronous active-high reset
//   io_in_valid / io_in_ready     per-requester handshake (one-hot ready)
//   io_in_bits_*                  packed per-requester fields, requester i at slice i
//   io_out_valid / io_out_ready   output stage handshake
//   io_out_bits_*                 registered winner fields, source index, class flags
//   io_busy                       output stage full or any requester valid
//   io_stat_grants/io_stat_stalls saturating counters, present only with
//                                 FLOAT_ARB_STATS_EN defined
module float_field_arbiter #(
   parameter int N     = 4,
   parameter int SRC_W = 2
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [N-1:0]       io_in_valid,
   output logic [N-1:0]       io_in_ready,
   input  logic [N-1:0]       io_in_bits_sign,
   input  logic [8*N-1:0]     io_in_bits_exponent,
   input  logic [23*N-1:0]    io_in_bits_significand,
   output logic               io_out_valid,
   input  logic               io_out_ready,
   output logic               io_out_bits_sign,
   output logic [7:0]         io_out_bits_exponent,
   output logic [22:0]        io_out_bits_significand,
   output logic [SRC_W-1:0]   io_out_bits_src,
   output logic               io_out_bits_isZero,
   output logic               io_out_bits_isInf,
   output logic               io_out_bits_isNaN,
`ifdef FLOAT_ARB_STATS_EN
   output logic [15:0]        io_stat_grants,
   output logic [15:0]        io_stat_stalls,
`endif
   output logic               io_busy
);

   logic [SRC_W-1:0] last;
   logic [SRC_W-1:0] cand;
   logic             any_valid;
   logic             can_load;
   logic             fire;
   logic             sel_sign;
   logic [7:0]       sel_exp;
   logic [22:0]      sel_sig;

   // Scan last+1, last+2, ... modulo N; the first valid requester wins.
   // The inner loop keeps every bit select at a constant index.
   always_comb begin
      cand      = '0;
      any_valid = 1'b0;
      for (int k = 1; k <= N; k++) begin
         for (int i = 0; i < N; i++) begin
            if (!any_valid && io_in_valid[i] && (((int'(last) + k) % N) == i)) begin
               any_valid = 1'b1;
               cand      = SRC_W'(i);
            end
         end
      end
   end

   always_comb begin
      sel_sign = 1'b0;
      sel_exp  = '0;
      sel_sig  = '0;
      for (int i = 0; i < N; i++) begin
         if (cand == SRC_W'(i)) begin
            sel_sign = io_in_bits_sign[i];
            sel_exp  = io_in_bits_exponent[8*i +: 8];
            sel_sig  = io_in_bits_significand[23*i +: 23];
         end
      end
   end

   assign can_load    = !io_out_valid || io_out_ready;
   // Reset gates the grant so no requester sees a handshake that would be lost.
   assign fire        = any_valid && can_load && !reset;
   assign io_in_ready = fire ? ({{(N-1){1'b0}}, 1'b1} << cand) : '0;
   assign io_busy     = io_out_valid || (|io_in_valid);

   always_ff @(posedge clock) begin
      if (reset) begin
         io_out_valid            <= 1'b0;
         io_out_bits_sign        <= 1'b0;
         io_out_bits_exponent    <= '0;
         io_out_bits_significand <= '0;
         io_out_bits_src         <= '0;
         io_out_bits_isZero      <= 1'b0;
         io_out_bits_isInf       <= 1'b0;
         io_out_bits_isNaN       <= 1'b0;
         last                    <= SRC_W'(N - 1);
      end else if (fire) begin
         io_out_valid            <= 1'b1;
         io_out_bits_sign        <= sel_sign;
         io_out_bits_exponent    <= sel_exp;
         io_out_bits_significand <= sel_sig;
         io_out_bits_src         <= cand;
         io_out_bits_isZero      <= (sel_exp == 8'h00) && (sel_sig == 23'd0);
         io_out_bits_isInf       <= (sel_exp == 8'hFF) && (sel_sig == 23'd0);
         io_out_bits_isNaN       <= (sel_exp == 8'hFF) && (sel_sig != 23'd0);
         last                    <= cand;
      end else if (io_out_ready) begin
         // Data registers keep their old contents; only valid drops.
         io_out_valid <= 1'b0;
      end
   end

`ifdef FLOAT_ARB_STATS_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         io_stat_grants <= '0;
         io_stat_stalls <= '0;
      end else begin
         if (fire && (io_stat_grants != 16'hFFFF))
            io_stat_grants <= io_stat_grants + 16'd1;
         if (io_out_valid && !io_out_ready && (io_stat_stalls != 16'hFFFF))
            io_stat_stalls <= io_stat_stalls + 16'd1;
      end
   end
`endif

endmodule

// File: doc/float_field_arbiter.md
Name: float_field_arbiter

Overview:
- Round-robin arbiter that shares one downstream single-precision float consumer among N requesters.
- Each requester offers a {sign, exponent[7:0], significand[22:0]} bundle over ready/valid.
- Winner is registered into a one-entry output stage together with its source index and IEEE-754 class flags.
- Sits between float-constant/field producers and the shared packing/compare unit.

Parameters:
- N, 4, number of requesters (2..16).
- SRC_W, 2, width of the source index; must equal clog2(N).

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- io_in_valid  input  N  per-requester valid.
- io_in_ready  output  N  per-requester ready; at most one bit high per cycle.
- io_in_bits_sign  input  N  sign bit; requester i at bit i.
- io_in_bits_exponent  input  8*N  exponent; requester i at [8i+7:8i].
- io_in_bits_significand  input  23*N  significand; requester i at [23i+22:23i].
- io_out_valid  output  1  output stage holds a bundle.
- io_out_ready  input  1  downstream accepts.
- io_out_bits_sign  output  1  registered sign.
- io_out_bits_exponent  output  8  registered exponent.
- io_out_bits_significand  output  23  registered significand.
- io_out_bits_src  output  SRC_W  index of the granted requester.
- io_out_bits_isZero  output  1  exponent==0 and significand==0.
- io_out_bits_isInf  output  1  exponent==8'hFF and significand==0.
- io_out_bits_isNaN  output  1  exponent==8'hFF and significand!=0.
- io_busy  output  1  io_out_valid, or any io_in_valid bit high.

Behaviour:
- Synchronous reset state:
  - io_out_valid=0.
  - All io_out_bits_* = 0.
  - Round-robin pointer last=N-1, so requester 0 has first priority.
- Output stage:
  - can_load = !io_out_valid || io_out_ready (combinational).
- Arbitration (combinational):
  - The candidate is the first valid requester scanning last+1, last+2, ... modulo N.
  - io_in_ready[cand]=can_load && (some io_in_valid high).
  - All other io_in_ready bits are 0.
  - io_in_ready never depends on io_in_valid of any other requester beyond the candidate selection.
- Transfer:
  - Requester i transfers when io_in_valid[i] && io_in_ready[i].
  - On the next edge the output stage loads requester i's fields, src=i and the class flags computed from the loaded fields.
  - last=i is updated on the same edge.
- Latency: exactly 1 cycle from input transfer to io_out_valid. No combinational path from io_in_* to io_out_*.
- Output stage update on each edge:
  - Output transfer without a new input: io_out_valid=0; data regs hold their values (don't-care).
  - Output transfer with a new input on the same edge: load the new bundle; io_out_valid stays 1. Full throughput, one bundle per cycle.
  - Stall (io_out_valid && !io_out_ready): all io_in_ready=0, the output holds stable and last is unchanged.
- Fairness: with all N requesters continuously valid and no stall, grants are issued in order 0,1,...,N-1,0,...
- No valid requesters: no grant, last unchanged.
- Pointer wrap: when last=N-1 the scan starts at 0.
- Reset mid-operation:
  - A pending output bundle is dropped.
  - Ready bits are 0 in the reset cycle.
  - Priority restarts at requester 0.
- Class flags:
  - Flags are mutually exclusive.
  - Denormals (exp=0, sig!=0) set no flag.
  - Sign does not affect any flag.

Optional Feature:
- Macro: FLOAT_ARB_STATS_EN.
- When defined, adds two outputs:
  - io_stat_grants [15:0]: counts input transfers.
  - io_stat_stalls [15:0]: counts cycles with io_out_valid && !io_out_ready.
- Both counters saturate at 16'hFFFF and clear on reset.
- When undefined, these ports and registers do not exist. All other behaviour is identical.

Test Plan:
- Reset, then requester 2 only valid with sign=1, exp=8'h80, sig=0, io_out_ready=1 -> io_in_ready=4'b0100 in the same cycle. Next cycle: io_out_valid=1, src=2, exp=8'h80, all class flags 0.
- All 4 requesters valid continuously, io_out_ready=1, 8 cycles -> src sequence 0,1,2,3,0,1,2,3 on consecutive cycles with no bubbles.
- Requester 1 transfers, then io_out_ready=0 for 3 cycles while requesters 0 and 3 are valid -> io_in_ready=0 throughout, output held at src=1. After ready returns: src=3, then src=0.
- Class inputs (exp,sig):
  - (0,0) -> isZero=1.
  - (FF,0) -> isInf=1.
  - (FF,1) -> isNaN=1.
  - (0,1) -> all flags 0.
  - Sign=1 gives the same flags.
- Assert reset while io_out_valid=1 with requesters valid -> next cycle io_out_valid=0. First grant after release goes to the lowest valid index.
- With FLOAT_ARB_STATS_EN: 5 transfers plus 2 stall cycles -> io_stat_grants=5, io_stat_stalls=2. Force io_stat_grants to 16'hFFFF, then one more transfer -> value stays 16'hFFFF.
